// File: rtl/fp_int_pkg.sv
// rtl/fp_int_pkg.sv - shared widths, FP16 constants and FSM states for the FP x INT normalizer
package fp_int_pkg;

  localparam int ACC_W     = 32;
  localparam int FRAC_BITS = 10;
  localparam int BIAS      = 15;
  localparam int EXP_W     = 5;
  localparam int MAN_W     = 10;
  localparam int FP_W      = 1 + EXP_W + MAN_W;
  localparam int SHIFT_W   = 5;

  // Biased exponent of a value whose leading one sits at mag[ACC_W-1] before any shift
  localparam int NORM_OFFSET = ACC_W - 1 - FRAC_BITS;

  localparam logic [FP_W-1:0]  POS_ZERO = 16'h0000;
  localparam logic [EXP_W-1:0] INF_EXP  = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp16_round_pack.sv
// rtl/fp16_round_pack.sv - round-to-nearest-even and exponent limiting of a normalized magnitude into FP16
module fp16_round_pack
  import fp_int_pkg::*;
(
  input  logic               sign,
  input  logic [ACC_W-2:0]   mag,
  input  logic [EXP_W-1:0]   e,
  input  logic [SHIFT_W-1:0] shift_cnt,
  output logic [FP_W-1:0]    fp_out,
  output logic               ovf,
  output logic               udf
);

  // mag holds the bits below the implied leading one
  logic [MAN_W-1:0]  man;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [MAN_W:0]    man_rnd;
  logic signed [6:0] exp_pre;
  logic signed [6:0] exp_fin;

  assign man      = mag[ACC_W-2 -: MAN_W];
  assign guard    = mag[ACC_W-2-MAN_W];
  assign sticky   = |mag[ACC_W-3-MAN_W:0];
  assign round_up = guard & (sticky | man[0]);
  assign man_rnd  = {1'b0, man} + {{MAN_W{1'b0}}, round_up};

  assign exp_pre = $signed(7'(NORM_OFFSET)) + $signed({2'b00, e}) - $signed({2'b00, shift_cnt});
  assign exp_fin = exp_pre + $signed({6'd0, man_rnd[MAN_W]});

  always_comb begin
    ovf    = 1'b0;
    udf    = 1'b0;
    fp_out = {sign, exp_fin[EXP_W-1:0], man_rnd[MAN_W-1:0]};
    if (exp_fin >= 7'sd31) begin
      fp_out = {sign, INF_EXP, {MAN_W{1'b0}}};
      ovf    = 1'b1;
    end else if (exp_fin <= 7'sd0) begin
      fp_out = {sign, {(FP_W-1){1'b0}}};
      udf    = 1'b1;
    end
  end

endmodule

// File: rtl/fp_int_norm.sv
// rtl/fp_int_norm.sv - converts a fixed-point accumulator sum plus block exponent into an FP16 result
module fp_int_norm
  import fp_int_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] acc_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  fp_out,
  output logic             ovf,
  output logic             udf
);

  state_t state;
  state_t state_next;

  logic               sign_q;
  logic [ACC_W-1:0]   mag_q;
  logic [EXP_W-1:0]   e_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [ACC_W-1:0]   acc_abs;
  logic [FP_W-1:0]    rp_fp;
  logic               rp_ovf;
  logic               rp_udf;

  // -2^31 negates to itself, which is exactly 0x80000000 read as unsigned
  assign acc_abs = acc_in[ACC_W-1] ? ('0 - acc_in) : acc_in;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (in_valid) state_next = ST_ABS;
      ST_ABS:   state_next = (mag_q == '0) ? ST_DONE : ST_NORM;
      ST_NORM:  if (mag_q[ACC_W-1]) state_next = ST_ROUND;
      ST_ROUND: state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q  <= 1'b0;
      mag_q   <= '0;
      e_q     <= '0;
      shift_q <= '0;
      fp_out  <= POS_ZERO;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q  <= acc_in[ACC_W-1];
            mag_q   <= acc_abs;
            e_q     <= exp_in;
            shift_q <= '0;
          end
        end
        ST_ABS: begin
          if (mag_q == '0) begin
            fp_out <= POS_ZERO;
            ovf    <= 1'b0;
            udf    <= 1'b0;
          end
        end
        ST_NORM: begin
          if (!mag_q[ACC_W-1]) begin
            mag_q   <= mag_q << 1;
            shift_q <= shift_q + SHIFT_W'(1);
          end
        end
        ST_ROUND: begin
          fp_out <= rp_fp;
          ovf    <= rp_ovf;
          udf    <= rp_udf;
        end
        default: ;
      endcase
    end
  end

  fp16_round_pack u_round_pack (
    .sign      (sign_q),
    .mag       (mag_q[ACC_W-2:0]),
    .e         (e_q),
    .shift_cnt (shift_q),
    .fp_out    (rp_fp),
    .ovf       (rp_ovf),
    .udf       (rp_udf)
  );

endmodule

// File: tb/tb_fp_int_norm.sv
// tb/tb_fp_int_norm.sv - directed self-checking bench for fp_int_norm against a value-level FP16 model
module tb_fp_int_norm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] acc_in = '0;
  logic [4:0]  exp_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] fp_out;
  logic        ovf;
  logic        udf;

  int n_cmp = 0;
  int n_err = 0;

  logic [17:0] exp_q[$];

  typedef struct packed {
    logic [31:0] acc;
    logic [4:0]  e;
    logic [15:0] fp;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs [0:11];

  fp_int_norm dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_in    (acc_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_out    (fp_out),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic int lead_pos(input logic [31:0] a);
    longint mag;
    int p;
    mag = {32'b0, a};
    if (a[31]) mag = 64'sh1_0000_0000 - mag;
    p = -1;
    for (int i = 0; i < 33; i++) if (mag[i]) p = i;
    return p;
  endfunction

  // Value = acc * 2^(e - 15 - 10); result packed as {ovf, udf, fp16}
  function automatic logic [17:0] model(input logic [31:0] a, input logic [4:0] e);
    longint mag, m, rem, half;
    int p, ex, sh;
    logic s;
    s   = a[31];
    mag = {32'b0, a};
    if (s) mag = 64'sh1_0000_0000 - mag;
    if (mag == 0) return 18'h0;
    p  = lead_pos(a);
    ex = p + int'(e) - 10;
    if (p > 10) begin
      sh   = p - 10;
      m    = mag >> sh;
      rem  = mag - (m << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 1;
    end else begin
      m = mag << (10 - p);
    end
    if (m == 2048) begin
      m  = 1024;
      ex = ex + 1;
    end
    if (ex >= 31) return {2'b10, s, 5'h1F, 10'h0};
    if (ex <= 0)  return {2'b01, s, 15'h0};
    return {2'b00, s, 5'(ex), 10'(m)};
  endfunction

  function automatic int lat_of(input logic [31:0] a);
    int p;
    p = lead_pos(a);
    if (p < 0) return 2;
    return 4 + (31 - p);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out_valid: got 1, expected 0");
      end else begin
        check("fp_out", {16'h0, fp_out}, {16'h0, exp_q[0][15:0]});
        check("ovf", {31'h0, ovf}, {31'h0, exp_q[0][17]});
        check("udf", {31'h0, udf}, {31'h0, exp_q[0][16]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [4:0] e, input bit push);
    int guard;
    guard    = 0;
    acc_in   = a;
    exp_in   = e;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) exp_q.push_back(model(a, e));
  endtask

  task automatic wait_done(input int lat);
    int cnt;
    cnt = 1;
    while (!out_valid && cnt < 64) begin
      check("in_ready_busy", {31'h0, in_ready}, 32'd0);
      @(posedge clk); #1;
      cnt++;
    end
    check("latency", cnt, lat);
  endtask

  task automatic release_out(input int hold);
    repeat (hold) begin
      check("in_ready_done", {31'h0, in_ready}, 32'd0);
      check("out_valid_hold", {31'h0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", {31'h0, out_valid}, 32'd0);
    check("in_ready_back", {31'h0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs = '{
      '{32'd1024,       5'd15, 16'h3C00, 1'b0, 1'b0},
      '{32'hFFFF_FA00,  5'd15, 16'hBE00, 1'b0, 1'b0},
      '{32'd0,          5'd7,  16'h0000, 1'b0, 1'b0},
      '{32'd2049,       5'd15, 16'h4000, 1'b0, 1'b0},
      '{32'd2051,       5'd15, 16'h4002, 1'b0, 1'b0},
      '{32'd4095,       5'd15, 16'h4400, 1'b0, 1'b0},
      '{32'h7FFF_FFFF,  5'd30, 16'h7C00, 1'b1, 1'b0},
      '{32'h8000_0000,  5'd30, 16'hFC00, 1'b1, 1'b0},
      '{32'd1,          5'd0,  16'h0000, 1'b0, 1'b1},
      '{32'hFFFF_FFFF,  5'd15, 16'h9400, 1'b0, 1'b0},
      '{32'h4000_0000,  5'd5,  16'h6400, 1'b0, 1'b0},
      '{32'h0000_0C01,  5'd3,  16'h1200, 1'b0, 1'b0}
    };

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_fp_out", {16'h0, fp_out}, 32'd0);
    check("rst_ovf", {31'h0, ovf}, 32'd0);
    check("rst_udf", {31'h0, udf}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      check("model_pin", {14'h0, model(vecs[i].acc, vecs[i].e)},
            {14'h0, vecs[i].ovf, vecs[i].udf, vecs[i].fp});
      send(vecs[i].acc, vecs[i].e, 1'b1);
      wait_done(lat_of(vecs[i].acc));
      release_out((i % 3) * 2);
    end

    // Result held for 10 cycles while the next input is already presented
    send(32'd1024, 5'd15, 1'b1);
    wait_done(25);
    acc_in   = 32'd2051;
    exp_in   = 5'd15;
    in_valid = 1'b1;
    repeat (10) begin
      check("hs_in_ready", {31'h0, in_ready}, 32'd0);
      check("hs_out_valid", {31'h0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_idle_ready", {31'h0, in_ready}, 32'd1);
    check("hs_idle_valid", {31'h0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(model(32'd2051, 5'd15));
    check("hs_accepted", {31'h0, in_ready}, 32'd0);
    wait_done(24);
    release_out(0);

    // Abort mid-normalization
    send(32'd1, 5'd0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", {31'h0, in_ready}, 32'd1);
    check("abort_out_valid", {31'h0, out_valid}, 32'd0);
    check("model_pin_post", {14'h0, model(32'd1024, 5'd15)}, 32'h0000_3C00);
    send(32'd1024, 5'd15, 1'b1);
    wait_done(25);
    release_out(1);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
